// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD conversion blocks.
// bin_width gives the binary width needed to hold any d-digit decimal value.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic int bin_width(input int d);
        return $clog2(10 ** d);
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One digit of the reverse double-dabble correction.
// A digit that is 8 or more after the right shift has 3 taken off (no borrow out).
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corr
);

    assign corr = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One shift-right-and-correct step per clock; a bad digit short-cuts straight to DONE.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int D = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic [4*D-1:0]              Bcd,
    output logic                        Ready,
    output logic                        Busy,
    output logic                        Done,
    output logic [bin_width(D)-1:0]     Bin,
    output logic                        Err
);

    localparam int W  = bin_width(D);
    localparam int N  = 4 * D;
    localparam int CW = $clog2(N);

    // Handshake: Start is taken on a rising edge only while Ready is high; Done
    // pulses for one cycle and Bin/Err stay valid until the next completion.

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   bcd_reg;
    logic [N-1:0]   bin_reg;
    logic [N-1:0]   bcd_shift;
    logic [N-1:0]   bcd_corr;
    logic [N-1:0]   bin_shift;
    logic [CW-1:0]  cnt;
    logic [D-1:0]   digit_bad;
    logic           bcd_bad;
    logic           last_step;
    logic           unused_bits;

    assign bcd_shift = {1'b0, bcd_reg[N-1:1]};
    assign bin_shift = {bcd_reg[0], bin_reg[N-1:1]};

    for (genvar g = 0; g < D; g++) begin : g_digit
        bcd_digit_corr u_corr (
            .digit (bcd_shift[4*g +: 4]),
            .corr  (bcd_corr[4*g +: 4])
        );
        assign digit_bad[g] = (Bcd[4*g +: 4] > BCD_MAX_DIGIT);
    end

    assign bcd_bad     = |digit_bad;
    assign last_step   = (cnt == CW'(N - 1));
    // Only the low W bits of the result matter; the rest are zero by construction.
    assign unused_bits = ^{bin_reg[0], bin_shift};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = bcd_bad ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            Bin     <= '0;
            Err     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Start) begin
                        bcd_reg <= Bcd;
                        bin_reg <= '0;
                        cnt     <= '0;
                        if (bcd_bad) begin
                            Bin <= '0;
                            Err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    bcd_reg <= bcd_corr;
                    bin_reg <= bin_shift;
                    cnt     <= cnt + 1'b1;
                    if (last_step) begin
                        Bin <= bin_shift[W-1:0];
                        Err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Ready = (state == IDLE);
    assign Busy  = (state == CONV);
    assign Done  = (state == DONE);

endmodule
